// File: rtl/hyperram_seq_if.sv
// hyperram_seq_if: user request/data ports plus the
// command, write-data and read-data wires to hyperram_raw.
interface hyperram_seq_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_READ_nWRITE;
  logic [31:0] REQ_ADDR;
  logic [9:0]  REQ_LEN;

  logic        WR_VALID;
  logic        WR_READY;
  logic [15:0] WR_DATA;
  logic [1:0]  WR_MASK;

  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic        RD_LAST;

  logic        INIT_DONE;
  logic        ERR;

  logic        HR_START;
  logic        HR_MEMORY_nREGISTER;
  logic        HR_READ_nWRITE;
  logic        HR_BURST_LINEAR_nWRAP;
  logic [28:0] HR_ADDR_HIGH;
  logic [2:0]  HR_ADDR_LOW;
  logic [9:0]  HR_BURST_LEN;
  logic [15:0] HR_REGISTER_DATA_IN;

  logic        HR_BUSY;
  logic        HR_DONE;

  logic [7:0]  HR_WRITE_DATA_1ST;
  logic [7:0]  HR_WRITE_DATA_2ND;
  logic        HR_WRITE_DATA_MASK_1ST;
  logic        HR_WRITE_DATA_MASK_2ND;
  logic        HR_WRITE_DATA_REQ;

  logic [7:0]  HR_READ_DATA_1ST;
  logic [7:0]  HR_READ_DATA_2ND;
  logic        HR_READ_DATA_VALID;

  modport slave (
    input  REQ_VALID, REQ_READ_nWRITE,
    input  REQ_ADDR, REQ_LEN,
    output REQ_READY,
    input  WR_VALID, WR_DATA, WR_MASK,
    output WR_READY,
    output RD_DATA, RD_VALID, RD_LAST,
    output INIT_DONE, ERR,
    output HR_START, HR_MEMORY_nREGISTER,
    output HR_READ_nWRITE, HR_BURST_LINEAR_nWRAP,
    output HR_ADDR_HIGH, HR_ADDR_LOW,
    output HR_BURST_LEN, HR_REGISTER_DATA_IN,
    input  HR_BUSY, HR_DONE,
    output HR_WRITE_DATA_1ST, HR_WRITE_DATA_2ND,
    output HR_WRITE_DATA_MASK_1ST,
    output HR_WRITE_DATA_MASK_2ND,
    input  HR_WRITE_DATA_REQ,
    input  HR_READ_DATA_1ST, HR_READ_DATA_2ND,
    input  HR_READ_DATA_VALID
  );

  modport master (
    output REQ_VALID, REQ_READ_nWRITE,
    output REQ_ADDR, REQ_LEN,
    input  REQ_READY,
    output WR_VALID, WR_DATA, WR_MASK,
    input  WR_READY,
    input  RD_DATA, RD_VALID, RD_LAST,
    input  INIT_DONE, ERR,
    input  HR_START, HR_MEMORY_nREGISTER,
    input  HR_READ_nWRITE, HR_BURST_LINEAR_nWRAP,
    input  HR_ADDR_HIGH, HR_ADDR_LOW,
    input  HR_BURST_LEN, HR_REGISTER_DATA_IN,
    output HR_BUSY, HR_DONE,
    input  HR_WRITE_DATA_1ST, HR_WRITE_DATA_2ND,
    input  HR_WRITE_DATA_MASK_1ST,
    input  HR_WRITE_DATA_MASK_2ND,
    output HR_WRITE_DATA_REQ,
    output HR_READ_DATA_1ST, HR_READ_DATA_2ND,
    output HR_READ_DATA_VALID
  );
endinterface

// File: rtl/hyperram_seq.sv
// hyperram_seq: CR0 init and user burst sequencer for
// hyperram_raw, with a show-ahead write FIFO and read return path.
module hyperram_seq #(
  parameter logic [15:0] CR0_VALUE  = 16'h8FEC,
  parameter int          FIFO_DEPTH = 32
) (
  input logic           IOCLK_0,
  input logic           RESET_N,
  hyperram_seq_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_CMD,
    INIT_RUN,
    IDLE,
    CMD,
    WR_RUN,
    RD_RUN,
    RD_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          init_done_q, init_done_d;
  logic          err_q, err_d;
  logic          hr_start_q, hr_start_d;
  logic          hr_mem_q, hr_mem_d;
  logic          hr_rnw_q, hr_rnw_d;
  logic          hr_lin_q, hr_lin_d;
  logic [28:0]   hr_ahi_q, hr_ahi_d;
  logic [2:0]    hr_alo_q, hr_alo_d;
  logic [9:0]    hr_blen_q, hr_blen_d;
  logic [15:0]   hr_reg_q, hr_reg_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          req_rnw_q, req_rnw_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [9:0]    req_len_q, req_len_d;
  logic [9:0]    word_cnt_q, word_cnt_d;
  logic          last_seen_q, last_seen_d;
  logic [3:0]    drain_cnt_q, drain_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [17:0]   mem_q [FIFO_DEPTH];

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          pop_err;
  logic [17:0]   head;
  logic          req_ready;
  logic          accept;
  logic          len_bad;
  logic [10:0]   need;
  logic          fits;
  logic          in_rd;
  logic          rd_word;
  logic          last_now;

  // FIFO status, head word and request qualifiers
  always_comb begin
    full     = fifo_cnt_q == CW'(FIFO_DEPTH);
    empty    = fifo_cnt_q == '0;
    push     = bus.WR_VALID && !full;
    pop      = bus.HR_WRITE_DATA_REQ && !empty;
    pop_err  = bus.HR_WRITE_DATA_REQ && empty;
    head     = mem_q[rd_ptr_q];
    req_ready = (state_q == IDLE) && !bus.HR_BUSY;
    accept   = bus.REQ_VALID && req_ready;
    len_bad  = 32'(bus.REQ_LEN) > 32'(FIFO_DEPTH - 1);
    need     = {1'b0, req_len_q} + 11'd1;
    fits     = 32'(fifo_cnt_q) >= 32'(need);
    in_rd    = (state_q == RD_RUN) ||
               (state_q == RD_DRAIN);
    rd_word  = in_rd && bus.HR_READ_DATA_VALID &&
               !last_seen_q;
    last_now = rd_word && (word_cnt_q == '0);
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Sequencer next state and registered command/read outputs
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    err_d       = pop_err;
    hr_start_d  = 1'b0;
    hr_mem_d    = hr_mem_q;
    hr_rnw_d    = hr_rnw_q;
    hr_lin_d    = hr_lin_q;
    hr_ahi_d    = hr_ahi_q;
    hr_alo_d    = hr_alo_q;
    hr_blen_d   = hr_blen_q;
    hr_reg_d    = hr_reg_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    req_rnw_d   = req_rnw_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    word_cnt_d  = word_cnt_q;
    last_seen_d = last_seen_q;
    drain_cnt_d = drain_cnt_q;

    if (rd_word) begin
      rd_valid_d = 1'b1;
      rd_data_d  = {bus.HR_READ_DATA_1ST,
                    bus.HR_READ_DATA_2ND};
      if (last_now) begin
        rd_last_d   = 1'b1;
        last_seen_d = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q - 10'd1;
      end
    end

    unique case (state_q)
      INIT_WAIT: begin
        if (!bus.HR_BUSY) begin
          state_d    = INIT_CMD;
          hr_start_d = 1'b1;
          hr_mem_d   = 1'b0;
          hr_rnw_d   = 1'b0;
          hr_lin_d   = 1'b0;
          hr_ahi_d   = 29'h100;
          hr_alo_d   = 3'd0;
          hr_blen_d  = 10'd0;
          hr_reg_d   = CR0_VALUE;
        end
      end
      INIT_CMD: state_d = INIT_RUN;
      INIT_RUN: begin
        if (bus.HR_DONE) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          req_rnw_d  = bus.REQ_READ_nWRITE;
          req_addr_d = bus.REQ_ADDR;
          req_len_d  = bus.REQ_LEN;
          if (!bus.REQ_READ_nWRITE && len_bad)
            err_d = 1'b1;
          else
            state_d = CMD;
        end
      end
      CMD: begin
        if (!bus.HR_BUSY && (req_rnw_q || fits)) begin
          hr_start_d  = 1'b1;
          hr_mem_d    = 1'b1;
          hr_rnw_d    = req_rnw_q;
          hr_lin_d    = 1'b1;
          hr_ahi_d    = req_addr_q[31:3];
          hr_alo_d    = req_addr_q[2:0];
          hr_blen_d   = req_len_q;
          word_cnt_d  = req_len_q;
          last_seen_d = 1'b0;
          state_d     = req_rnw_q ? RD_RUN : WR_RUN;
        end
      end
      WR_RUN: begin
        if (bus.HR_DONE) state_d = IDLE;
      end
      RD_RUN: begin
        if (bus.HR_DONE) begin
          if (last_seen_q || last_now) begin
            state_d = IDLE;
          end else begin
            state_d     = RD_DRAIN;
            drain_cnt_d = 4'd0;
          end
        end
      end
      RD_DRAIN: begin
        if (last_now) begin
          state_d = IDLE;
        end else if (drain_cnt_q == 4'd15) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge IOCLK_0 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= INIT_WAIT;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      hr_start_q  <= 1'b0;
      hr_mem_q    <= 1'b0;
      hr_rnw_q    <= 1'b0;
      hr_lin_q    <= 1'b0;
      hr_ahi_q    <= '0;
      hr_alo_q    <= '0;
      hr_blen_q   <= '0;
      hr_reg_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      req_rnw_q   <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      word_cnt_q  <= '0;
      last_seen_q <= 1'b0;
      drain_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      hr_start_q  <= hr_start_d;
      hr_mem_q    <= hr_mem_d;
      hr_rnw_q    <= hr_rnw_d;
      hr_lin_q    <= hr_lin_d;
      hr_ahi_q    <= hr_ahi_d;
      hr_alo_q    <= hr_alo_d;
      hr_blen_q   <= hr_blen_d;
      hr_reg_q    <= hr_reg_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      req_rnw_q   <= req_rnw_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      word_cnt_q  <= word_cnt_d;
      last_seen_q <= last_seen_d;
      drain_cnt_q <= drain_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // FIFO storage; occupancy alone defines validity
  always_ff @(posedge IOCLK_0) begin
    if (push)
      mem_q[wr_ptr_q] <= {bus.WR_DATA, bus.WR_MASK};
  end

  assign bus.REQ_READY  = req_ready;
  assign bus.WR_READY   = !full;
  assign bus.RD_DATA    = rd_data_q;
  assign bus.RD_VALID   = rd_valid_q;
  assign bus.RD_LAST    = rd_last_q;
  assign bus.INIT_DONE  = init_done_q;
  assign bus.ERR        = err_q;

  assign bus.HR_START              = hr_start_q;
  assign bus.HR_MEMORY_nREGISTER   = hr_mem_q;
  assign bus.HR_READ_nWRITE        = hr_rnw_q;
  assign bus.HR_BURST_LINEAR_nWRAP = hr_lin_q;
  assign bus.HR_ADDR_HIGH          = hr_ahi_q;
  assign bus.HR_ADDR_LOW           = hr_alo_q;
  assign bus.HR_BURST_LEN          = hr_blen_q;
  assign bus.HR_REGISTER_DATA_IN   = hr_reg_q;

  assign bus.HR_WRITE_DATA_1ST =
    empty ? 8'h00 : head[17:10];
  assign bus.HR_WRITE_DATA_2ND =
    empty ? 8'h00 : head[9:2];
  assign bus.HR_WRITE_DATA_MASK_1ST =
    empty ? 1'b1 : head[1];
  assign bus.HR_WRITE_DATA_MASK_2ND =
    empty ? 1'b1 : head[0];
endmodule

// File: doc/hyperram_seq.md
HYPERRAM_SEQ -- requirements
Module: hyperram_seq

Interface
REQ-001 Parameter CR0_VALUE, default 16'h8FEC: value written to HyperRAM CR0 at init.
REQ-002 Parameter FIFO_DEPTH, default 32, power of two: write-data FIFO depth in 16-bit words.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low. IOCLK_0 in 1: sole clock. RESET_N in 1: reset.
REQ-004 User request port:
- REQ_VALID in 1; REQ_READY out 1.
- REQ_READ_nWRITE in 1: 1 = read, 0 = write.
- REQ_ADDR in 32: word address.
- REQ_LEN in 10: burst length minus 1, in words.
REQ-005 User write port:
- WR_VALID in 1; WR_READY out 1.
- WR_DATA in 16: [15:8] is the first byte.
- WR_MASK in 2: [1] masks the first byte, [0] masks the second; 1 = masked.
REQ-006 User read port: RD_DATA out 16; RD_VALID out 1; RD_LAST out 1.
REQ-007 Status: INIT_DONE out 1; ERR out 1 (one-cycle pulse).
REQ-008 Command outputs to hyperram_raw:
- HR_START out 1; HR_MEMORY_nREGISTER out 1; HR_READ_nWRITE out 1; HR_BURST_LINEAR_nWRAP out 1.
- HR_ADDR_HIGH out 29; HR_ADDR_LOW out 3; HR_BURST_LEN out 10; HR_REGISTER_DATA_IN out 16.
REQ-009 Status inputs from hyperram_raw: HR_BUSY in 1; HR_DONE in 1.
REQ-010 Write-data signals to/from hyperram_raw:
- HR_WRITE_DATA_1ST out 8; HR_WRITE_DATA_2ND out 8.
- HR_WRITE_DATA_MASK_1ST out 1; HR_WRITE_DATA_MASK_2ND out 1.
- HR_WRITE_DATA_REQ in 1.
REQ-011 Read-data inputs from hyperram_raw: HR_READ_DATA_1ST in 8; HR_READ_DATA_2ND in 8; HR_READ_DATA_VALID in 1.

Function
REQ-012 FSM states SHALL be INIT_WAIT, INIT_CMD, INIT_RUN, IDLE, CMD, WR_RUN, RD_RUN, RD_DRAIN.
REQ-013 INIT_WAIT: wait for HR_BUSY=0, then go to INIT_CMD.
REQ-014 INIT_CMD: assert HR_START for one cycle with a register write, then go to INIT_RUN. Field values:
- HR_MEMORY_nREGISTER=0, HR_READ_nWRITE=0.
- HR_ADDR_HIGH=29'h100, HR_ADDR_LOW=0.
- HR_REGISTER_DATA_IN=CR0_VALUE.
REQ-015 INIT_RUN: on HR_DONE, set INIT_DONE=1 (sticky until reset) and go to IDLE.
REQ-016 REQ_READY SHALL be 1 only in IDLE with HR_BUSY=0; a request is accepted on REQ_VALID&&REQ_READY, and its fields are latched.
REQ-017 On an accepted write with REQ_LEN > FIFO_DEPTH-1: pulse ERR, drop the request, stay in IDLE.
REQ-018 CMD:
- Write: wait until FIFO occupancy >= REQ_LEN+1, then pulse HR_START and go to WR_RUN.
- Read: pulse HR_START immediately and go to RD_RUN.
REQ-019 While HR_START is high, the command outputs SHALL carry the latched request:
- HR_MEMORY_nREGISTER=1, HR_BURST_LINEAR_nWRAP=1.
- HR_ADDR_HIGH=REQ_ADDR[31:3], HR_ADDR_LOW=REQ_ADDR[2:0].
- HR_BURST_LEN=REQ_LEN.
REQ-020 HR_START SHALL be high for exactly one cycle per command, and never while HR_BUSY=1.
REQ-021 Write FIFO: show-ahead.
- Push on WR_VALID&&WR_READY; WR_READY = not full.
- Pop on every cycle HR_WRITE_DATA_REQ=1.
- Simultaneous push and pop leave occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH.
REQ-022 HR_WRITE_DATA_1ST/2ND and the masks SHALL be driven combinationally from the FIFO head, so they are valid in the same cycle as HR_WRITE_DATA_REQ.
REQ-023 A pop on an empty FIFO SHALL pulse ERR and drive data 8'h00 with masks 1.
REQ-024 WR_RUN: on HR_DONE go to IDLE.
REQ-025 RD_RUN data path:
- Each HR_READ_DATA_VALID registers RD_DATA={HR_READ_DATA_1ST,HR_READ_DATA_2ND} and RD_VALID=1 one cycle later.
- A 10-bit word counter is decremented per word.
- RD_LAST=1 on word REQ_LEN+1.
- There is no backpressure on the read port.
REQ-026 RD_RUN exit:
- Go to IDLE once both the last word and HR_DONE have been seen, in either order.
- If HR_DONE is seen first, go to RD_DRAIN.
REQ-027 RD_DRAIN: wait at most 16 cycles for the remaining words. On timeout: pulse ERR, suppress RD_LAST, go to IDLE.
REQ-028 Read words arriving outside RD_RUN/RD_DRAIN SHALL be discarded.
REQ-029 Reset values of outputs: all 0 except WR_READY=1 and HR_WRITE_DATA_MASK_*=1. FSM goes to INIT_WAIT; FIFO is emptied.

Reset
REQ-030 Asserting RESET_N=0 mid-burst SHALL asynchronously clear the FSM, FIFO, counters and outputs.
REQ-031 After release, the block SHALL redo the CR0 init before accepting any request.

Verification
REQ-032 Init: release reset with HR_BUSY=0 -> one HR_START with register write 16'h8FEC to ADDR_HIGH 29'h100; INIT_DONE=1 after HR_DONE.
REQ-033 Write: push 4 words 16'h1122..16'h7788, then request write addr 32'h40, LEN 3 -> one HR_START with ADDR_HIGH=8, ADDR_LOW=0, BURST_LEN=3; bytes 11,22 on the first REQ cycle; FIFO empty after.
REQ-034 Deferred start: request write LEN 7 with 2 words in FIFO -> no HR_START until the 8th word is pushed.
REQ-035 Read: read LEN 3, model returns 4 words -> 4 RD_VALID pulses, RD_LAST on the 4th only, in order.
REQ-036 Errors:
- Write with LEN 40 -> ERR pulse, no HR_START, REQ_READY back to 1.
- Read where the model returns 2 of 4 words -> ERR 16 cycles after HR_DONE, no RD_LAST.
REQ-037 Reset mid-write burst -> all outputs return to reset values, followed by a fresh CR0 init.
